nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder that time-multiplexes one 4-bit carry-lookahead adder slice across a NIBBLES*4-bit operand pair, least significant nibble first.
- Sits directly upstream of the 4-bit CLA. Latches operands, feeds the slice one nibble per clock with a registered carry, and reassembles the sum.
- Gives FPGA lab designs wide addition at the area cost of a single slice.

Parameters:
- NIBBLES, 4, number of 4-bit digits per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when ready=1
- a  in  W  operand A; sampled on the accepted start cycle only
- b  in  W  operand B; sampled on the accepted start cycle only
- cin  in  1  carry-in to nibble 0; sampled with a/b
- ready  out  1  1 in IDLE and DONE; block accepts start
- busy  out  1  1 in RUN
- done  out  1  one-cycle pulse; result valid
- sum  out  W  result; held from done until the next accepted start
- cout  out  1  carry out of the top nibble; held like sum
- ovf  out  1  two's-complement overflow; held like sum

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE, idx=0, carry_r=0, a_r=b_r=0.
  - sum=0, cout=0, ovf=0, done=0, busy=0, ready=1.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1: a_r<=a, b_r<=b, carry_r<=cin, idx<=0, go to RUN.
  - start=0: stay in IDLE.
- RUN, each cycle:
  - Slice inputs are a_r[4*idx+:4], b_r[4*idx+:4] and carry_r.
  - Slice sum is written into sum_r[4*idx+:4]; carry_r<=slice carryout.
  - idx<NIBBLES-1: idx<=idx+1.
  - idx==NIBBLES-1: commit cout<=slice carryout; ovf<=(a_r[W-1]==b_r[W-1]) && (slice sum bit3 != a_r[W-1]); go to DONE.
  - start is ignored in RUN. Inputs a/b/cin may change freely without effect.
- DONE:
  - done=1 for exactly this cycle; sum/cout/ovf already valid.
  - start=1: accept as in IDLE and go to RUN (back-to-back).
  - start=0: go to IDLE.
- Latency: start accepted at edge k, done high in cycle k+NIBBLES+1. Throughput is one result per NIBBLES+1 cycles.
- sum port comes from sum_r. While RUN overwrites nibbles, sum is undefined to consumers until done. cout/ovf keep their previous values until the final RUN cycle.
- Arithmetic: unsigned modulo 2^W, {cout,sum} = a+b+cin exactly. ovf follows the signed interpretation.
- Boundary cases:
  - NIBBLES=1: RUN lasts one cycle.
  - A carry rippling through all nibbles (e.g. all-ones + 1) must propagate via carry_r with no lost cycle.
  - reset asserted during RUN aborts the operation, returns to IDLE with zeroed outputs next edge, and does not pulse done.
  - reset and start in the same cycle: reset wins.

Decomposition:
- Shared package holds:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
  - nibble width constant DIGIT_W=4
- One sub-module: the existing 4-bit carry-lookahead adder (jcarrylookaheadadder, port order sum, carryout, A, B, carryin), instantiated once.
- Counter, state machine and operand/sum registers stay in this module.

Test Plan:
- NIBBLES=4; start with a=0x0000, b=0x0000, cin=0 -> done exactly 5 cycles after the start edge; sum=0x0000, cout=0, ovf=0; ready=0 during the 4 RUN cycles.
- a=0x0003, b=0x0002, cin=1 -> sum=0x0006, cout=0. Then a=0x0007, b=0x000A, cin=0 -> sum=0x0011, cout=0 (carry crosses nibble 0→1).
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Back-to-back and busy filtering:
  - start held high continuously with changing operands -> results accepted only in IDLE/DONE cycles; one done every 5 cycles.
  - Operands driven during RUN do not alter the in-flight result.
- Reset mid-op: assert reset during the 2nd RUN cycle of 0xFFFF+0x0001 -> next cycle state IDLE, sum=0, cout=0, no done pulse. A subsequent 0x1234+0x1111 gives 0x2345.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial wide adder: FSM state encoding and digit width.
package nibble_serial_adder_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int DIGIT_W = 4;

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// 4-bit carry-lookahead adder slice; every carry is computed directly from
// generate/propagate terms so there is no ripple inside the slice.
module jcarrylookaheadadder (
  output logic [3:0] sum,
  output logic       carryout,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       carryin
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = A & B;
  assign p = A ^ B;

  assign c[0] = carryin;
  assign c[1] = g[0] | (p[0] & carryin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carryin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & carryin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & carryin);

  assign sum      = p ^ c[3:0];
  assign carryout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit CLA slice over NIBBLES clocks, low nibble first,
// carrying between nibbles through carry_r.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [DIGIT_W*NIBBLES-1:0]   a,
  input  logic [DIGIT_W*NIBBLES-1:0]   b,
  input  logic                         cin,
  output logic                         ready,
  output logic                         busy,
  output logic                         done,
  output logic [DIGIT_W*NIBBLES-1:0]   sum,
  output logic                         cout,
  output logic                         ovf
);

  localparam int W     = DIGIT_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  logic [1:0]         state;
  logic [IDX_W-1:0]   idx;
  logic               carry_r;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;
  logic [W-1:0]       sum_r;
  logic               cout_r;
  logic               ovf_r;
  logic [DIGIT_W-1:0] a_nib;
  logic [DIGIT_W-1:0] b_nib;
  logic [DIGIT_W-1:0] slice_sum;
  logic               slice_cout;
  logic               accept;

  assign a_nib  = a_r[DIGIT_W*idx +: DIGIT_W];
  assign b_nib  = b_r[DIGIT_W*idx +: DIGIT_W];
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  jcarrylookaheadadder u_slice (
    .sum      (slice_sum),
    .carryout (slice_cout),
    .A        (a_nib),
    .B        (b_nib),
    .carryin  (carry_r)
  );

  // DONE accepts a new start just like IDLE, giving one result every NIBBLES+1 cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept) begin
      a_r     <= a;
      b_r     <= b;
      carry_r <= cin;
      idx     <= '0;
      state   <= S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          sum_r[DIGIT_W*idx +: DIGIT_W] <= slice_sum;
          carry_r <= slice_cout;
          if (idx == LAST) begin
            cout_r <= slice_cout;
            ovf_r  <= (a_r[W-1] == b_r[W-1]) && (slice_sum[DIGIT_W-1] != a_r[W-1]);
            state  <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready = (state == S_IDLE) || (state == S_DONE);
  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);
  assign sum   = sum_r;
  assign cout  = cout_r;
  assign ovf   = ovf_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized self-checking bench for nibble_serial_adder against an integer
// reference of a+b+cin; a second NIBBLES=1 instance covers the single-slice case.
module tb_nibble_serial_adder;

  localparam int N  = 4;
  localparam int W  = 4 * N;
  localparam int TO = 20;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  logic         start1;
  logic [3:0]   a1;
  logic [3:0]   b1;
  logic         cin1;
  logic         ready1;
  logic         busy1;
  logic         done1;
  logic [3:0]   sum1;
  logic         cout1;
  logic         ovf1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  // Reference: {ovf, cout, sum} from plain unsigned and signed integer arithmetic.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    longint unsigned u;
    longint          s;
    longint          smax;
    logic            o;
    u    = longint'(x) + longint'(y) + longint'(c);
    s    = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
    smax = (longint'(1) <<< (W - 1)) - 1;
    o    = (s > smax) || (s < -smax - 1);
    return {o, u[W], u[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation from a ready cycle and returns in the DONE cycle
  // (or after TO cycles); scrambles inputs and start while the op is in flight.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       output int lat, output bit run_bad);
    start = 1'b1; a = ta; b = tb; cin = tc;
    tick();
    lat = 0;
    run_bad = 1'b0;
    while (done !== 1'b1 && lat < TO) begin
      if (ready !== 1'b0 || busy !== 1'b1) run_bad = 1'b1;
      start = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; a = '1; b = '1; cin = 1'b1;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    tick();
    tick();
    tests++;
    if ({ready, busy, done, cout, ovf} !== 5'b10000 || sum !== '0) begin
      fails++;
      $display("[TB] FAIL reset_state got r/b/d/c/o=%b sum=%h want 10000 sum=0000",
               {ready, busy, done, cout, ovf}, sum);
    end
    reset = 1'b0; start = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    int lat;
    bit run_bad;
    logic [W-1:0] held;
    do_op('0, '0, 1'b0, lat, run_bad);
    tests++;
    if (lat != N) begin
      fails++;
      $display("[TB] FAIL latency got %0d edges after accept want %0d", lat, N);
    end
    tests++;
    if (run_bad) begin
      fails++;
      $display("[TB] FAIL run_flags got ready/busy wrong during RUN want ready=0 busy=1");
    end
    tests++;
    if ({cout, ovf} !== 2'b00 || sum !== '0) begin
      fails++;
      $display("[TB] FAIL zero_sum got %h c=%b o=%b want 0000 c=0 o=0", sum, cout, ovf);
    end
    held = sum;
    do_op(16'h1234, 16'h0F0F, 1'b0, lat, run_bad);
    held = sum;
    tick();
    tests++;
    if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL done_pulse got done=%b ready=%b busy=%b want 0 1 0", done, ready, busy);
    end
    tick();
    tests++;
    if (sum !== 16'h2143) begin
      fails++;
      $display("[TB] FAIL sum_hold got %h want 2143 (first seen %h)", sum, held);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [6] = '{16'h0003, 16'h0007, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
    logic [W-1:0] vb [6] = '{16'h0002, 16'h000A, 16'h0001, 16'hFFFF, 16'h0001, 16'h8000};
    logic         vc [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W+1:0] exp;
    int lat;
    bit run_bad;
    for (int i = 0; i < 6; i++) begin
      exp = ref_add(va[i], vb[i], vc[i]);
      do_op(va[i], vb[i], vc[i], lat, run_bad);
      tests++;
      if (lat != N || {ovf, cout, sum} !== exp) begin
        fails++;
        $display("[TB] FAIL directed_%0d got lat=%0d o=%b c=%b sum=%h want lat=%0d o=%b c=%b sum=%h",
                 i, lat, ovf, cout, sum, N, exp[W+1], exp[W], exp[W-1:0]);
      end
      if (i % 2 == 1) tick();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W+1:0] exp;
    int lat;
    bit run_bad;
    for (int i = 0; i < 25; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      if (i % 5 == 0) rb = ~ra;
      exp = ref_add(ra, rb, rc);
      do_op(ra, rb, rc, lat, run_bad);
      tests++;
      if (lat != N || run_bad || {ovf, cout, sum} !== exp) begin
        fails++;
        $display("[TB] FAIL random_%0d a=%h b=%h cin=%b got lat=%0d o=%b c=%b sum=%h want o=%b c=%b sum=%h",
                 i, ra, rb, rc, lat, ovf, cout, sum, exp[W+1], exp[W], exp[W-1:0]);
      end
      for (int k = $urandom_range(0, 2); k > 0; k--) tick();
    end
  endtask

  // start held high: accepts land every N+1 cycles, results N+1 cycles after their operands.
  task automatic test_back_to_back();
    logic [W-1:0] ha [40];
    logic [W-1:0] hb [40];
    logic         hc [40];
    logic [W+1:0] exp;
    bit           want_done;
    start = 1'b0;
    tick();
    tick();
    for (int c = 0; c < 40; c++) begin
      want_done = (c > 0) && (c % (N + 1) == 0);
      tests++;
      if (done !== want_done) begin
        fails++;
        $display("[TB] FAIL b2b_done_c%0d got %b want %b", c, done, want_done);
      end
      if (want_done) begin
        exp = ref_add(ha[c-N-1], hb[c-N-1], hc[c-N-1]);
        tests++;
        if ({ovf, cout, sum} !== exp) begin
          fails++;
          $display("[TB] FAIL b2b_result_c%0d got o=%b c=%b sum=%h want o=%b c=%b sum=%h",
                   c, ovf, cout, sum, exp[W+1], exp[W], exp[W-1:0]);
        end
      end
      ha[c] = W'($urandom);
      hb[c] = W'($urandom);
      hc[c] = 1'($urandom_range(0, 1));
      start = 1'b1; a = ha[c]; b = hb[c]; cin = hc[c];
      tick();
    end
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_op();
    int lat;
    bit run_bad;
    int done_seen;
    do_op(16'h8000, 16'h8000, 1'b0, lat, run_bad);
    tick();
    start = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if ({ready, busy, done, cout, ovf} !== 5'b10000 || sum !== '0) begin
      fails++;
      $display("[TB] FAIL reset_mid_op got r/b/d/c/o=%b sum=%h want 10000 sum=0000",
               {ready, busy, done, cout, ovf}, sum);
    end
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (done === 1'b1) done_seen++;
      tick();
    end
    tests++;
    if (done_seen != 0) begin
      fails++;
      $display("[TB] FAIL reset_no_done got %0d done pulses want 0", done_seen);
    end
    do_op(16'h1234, 16'h1111, 1'b0, lat, run_bad);
    tests++;
    if (lat != N || sum !== 16'h2345 || cout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL after_reset got lat=%0d sum=%h c=%b want lat=%0d sum=2345 c=0",
               lat, sum, cout, N);
    end
    tick();
    start = 1'b1; reset = 1'b1; a = 16'h0101; b = 16'h0202;
    tick();
    start = 1'b0; reset = 1'b0;
    tests++;
    if (busy !== 1'b0 || ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_beats_start got busy=%b ready=%b want 0 1", busy, ready);
    end
  endtask

  task automatic test_single_nibble();
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rc;
    logic [4:0] full;
    logic       o;
    int         s;
    for (int i = 0; i < 10; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rc = 1'($urandom_range(0, 1));
      if (i == 0) begin ra = 4'hF; rb = 4'h0; rc = 1'b1; end
      full = {1'b0, ra} + {1'b0, rb} + {4'b0, rc};
      s = int'($signed(ra)) + int'($signed(rb)) + int'(rc);
      o = (s > 7) || (s < -8);
      start1 = 1'b1; a1 = ra; b1 = rb; cin1 = rc;
      tick();
      start1 = 1'b0; a1 = ~ra;
      tests++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        fails++;
        $display("[TB] FAIL n1_run_%0d got busy=%b done=%b want 1 0", i, busy1, done1);
      end
      tick();
      tests++;
      if (done1 !== 1'b1 || {ovf1, cout1, sum1} !== {o, full}) begin
        fails++;
        $display("[TB] FAIL n1_result_%0d got d=%b o=%b c=%b sum=%h want d=1 o=%b c=%b sum=%h",
                 i, done1, ovf1, cout1, sum1, o, full[4], full[3:0]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    test_single_nibble();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
